pic_pc_sequencer: RTL and testbench

// - Fetch/execute sequencer for the PIC16F54 core: owns the fetch address, the

---
 rtl/pic_pc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pic_pc_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pic_pc_sequencer.sv
// Fetch/execute PC sequencer for the PIC16F54 core: fetch address, executing PC, 2-level return stack, SLEEP hold.
// Optional stack depth checking with sticky overflow/underflow flags is enabled by defining PIC_SEQ_STK_CHECK_EN.
module pic_pc_sequencer #(
    parameter int              PC_W    = 9,
    parameter logic [PC_W-1:0] RST_VEC = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     instr,
    input  logic            goto_en,
    input  logic            call_en,
    input  logic            retlw_en,
    input  logic            pcl_wr,
    input  logic [7:0]      pcl_data,
    input  logic            skip_en,
    input  logic            skip_cond,
    input  logic            sleep_en,
    input  logic            wdt_to,
`ifdef PIC_SEQ_STK_CHECK_EN
    output logic            stk_ovf,
    output logic            stk_unf,
`endif
    output logic [PC_W-1:0] rom_adrs,
    output logic [PC_W-1:0] pc,
    output logic            exec_valid,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_KILL  = 2'd2,
        ST_SLEEP = 2'd3
    } seq_state_e;

    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] rom_adrs_q, rom_adrs_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] s1_q, s1_d;
    logic [PC_W-1:0] s2_q, s2_d;
    logic            exec_valid_q, exec_valid_d;
    logic            halted_q, halted_d;
    logic            call_take_s;
    logic            retlw_take_s;

`ifdef PIC_SEQ_STK_CHECK_EN
    logic [1:0]      depth_q, depth_d;
    logic            stk_ovf_q, stk_ovf_d;
    logic            stk_unf_q, stk_unf_d;
`endif

    // Next-state, redirect target and return-stack update
    always_comb begin
        state_d      = state_q;
        rom_adrs_d   = rom_adrs_q;
        pc_d         = pc_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        call_take_s  = 1'b0;
        retlw_take_s = 1'b0;

        case (state_q)
            ST_FILL, ST_KILL: begin
                rom_adrs_d = rom_adrs_q + PC_ONE;
                pc_d       = rom_adrs_q;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                // Strobes are only honoured here, where the slot is architecturally executed
                rom_adrs_d = rom_adrs_q + PC_ONE;
                pc_d       = rom_adrs_q;
                if (sleep_en) begin
                    rom_adrs_d = rom_adrs_q;
                    pc_d       = pc_q;
                    state_d    = ST_SLEEP;
                end else if (retlw_en) begin
                    retlw_take_s = 1'b1;
                    rom_adrs_d   = s1_q;
                    s1_d         = s2_q;
                    state_d      = ST_KILL;
                end else if (call_en) begin
                    call_take_s = 1'b1;
                    rom_adrs_d  = PC_W'({1'b0, instr[7:0]});
                    s2_d        = s1_q;
                    s1_d        = pc_q + PC_ONE;
                    state_d     = ST_KILL;
                end else if (goto_en) begin
                    rom_adrs_d = PC_W'(instr[8:0]);
                    state_d    = ST_KILL;
                end else if (pcl_wr) begin
                    rom_adrs_d = PC_W'({1'b0, pcl_data});
                    state_d    = ST_KILL;
                end else if (skip_en && skip_cond) begin
                    state_d = ST_KILL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SLEEP: begin
                if (wdt_to) begin
                    rom_adrs_d = RST_VEC;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_SLEEP;
                end
            end
            default: begin
                rom_adrs_d = RST_VEC;
                pc_d       = RST_VEC;
                state_d    = ST_FILL;
            end
        endcase

        exec_valid_d = (state_d == ST_RUN);
        halted_d     = (state_d == ST_SLEEP);
    end

`ifdef PIC_SEQ_STK_CHECK_EN
    // Saturating depth tracking with sticky misuse flags; data path is unaffected
    always_comb begin
        depth_d   = depth_q;
        stk_ovf_d = stk_ovf_q;
        stk_unf_d = stk_unf_q;
        if (call_take_s) begin
            if (depth_q == 2'd2) begin
                stk_ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 2'd1;
            end
        end else if (retlw_take_s) begin
            if (depth_q == 2'd0) begin
                stk_unf_d = 1'b1;
            end else begin
                depth_d = depth_q - 2'd1;
            end
        end else begin
            depth_d = depth_q;
        end
    end

    // Stack checker registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth_q   <= 2'd0;
            stk_ovf_q <= 1'b0;
            stk_unf_q <= 1'b0;
        end else begin
            depth_q   <= depth_d;
            stk_ovf_q <= stk_ovf_d;
            stk_unf_q <= stk_unf_d;
        end
    end

    assign stk_ovf = stk_ovf_q;
    assign stk_unf = stk_unf_q;
`endif

    // Sequencer state, addresses, stack and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FILL;
            rom_adrs_q   <= RST_VEC;
            pc_q         <= RST_VEC;
            s1_q         <= PC_ZERO;
            s2_q         <= PC_ZERO;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_adrs_q   <= rom_adrs_d;
            pc_q         <= pc_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            exec_valid_q <= exec_valid_d;
            halted_q     <= halted_d;
        end
    end

    assign rom_adrs   = rom_adrs_q;
    assign pc         = pc_q;
    assign exec_valid = exec_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_pic_pc_sequencer.sv
// Directed bench for pic_pc_sequencer: branches, calls, skips, SLEEP/WDT wake and reset abort.
module tb_pic_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [11:0] instr;
    logic        goto_en, call_en, retlw_en, pcl_wr;
    logic [7:0]  pcl_data;
    logic        skip_en, skip_cond, sleep_en, wdt_to;
    logic [8:0]  rom_adrs, pc;
    logic        exec_valid, halted;
`ifdef PIC_SEQ_STK_CHECK_EN
    logic        stk_ovf, stk_unf;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    pic_pc_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr),
        .goto_en(goto_en), .call_en(call_en), .retlw_en(retlw_en),
        .pcl_wr(pcl_wr), .pcl_data(pcl_data),
        .skip_en(skip_en), .skip_cond(skip_cond),
        .sleep_en(sleep_en), .wdt_to(wdt_to),
`ifdef PIC_SEQ_STK_CHECK_EN
        .stk_ovf(stk_ovf), .stk_unf(stk_unf),
`endif
        .rom_adrs(rom_adrs), .pc(pc),
        .exec_valid(exec_valid), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_strobes();
        goto_en = 1'b0; call_en = 1'b0; retlw_en = 1'b0; pcl_wr = 1'b0;
        skip_en = 1'b0; skip_cond = 1'b0; sleep_en = 1'b0; wdt_to = 1'b0;
        instr = 12'h000; pcl_data = 8'h00;
    endtask

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_slot(input string tag, input logic [8:0] e_pc, input logic e_ev);
        check_vec({tag, ".pc"}, {7'd0, pc}, {7'd0, e_pc});
        check_vec({tag, ".ev"}, {15'd0, exec_valid}, {15'd0, e_ev});
    endtask

    // Execute a branch-type strobe already driven, then land on the target
    task automatic redirect(input string tag, input logic [8:0] kill_pc, input logic [8:0] tgt);
        step();
        clr_strobes();
        exp_slot({tag, ".kill"}, kill_pc, 1'b0);
        check_vec({tag, ".rom"}, {7'd0, rom_adrs}, {7'd0, tgt});
        step();
        exp_slot({tag, ".land"}, tgt, 1'b1);
    endtask

    task automatic do_goto(input string tag, input logic [8:0] kill_pc, input logic [8:0] tgt);
        goto_en = 1'b1;
        instr   = {3'b000, tgt};
        redirect(tag, kill_pc, tgt);
    endtask

    initial begin
        rst = 1'b0;
        clr_strobes();
        #12;
        check_vec("rst.rom", {7'd0, rom_adrs}, 16'h01FF);
        check_vec("rst.pc", {7'd0, pc}, 16'h01FF);
        check_vec("rst.ev", {15'd0, exec_valid}, 16'h0000);
        check_vec("rst.halt", {15'd0, halted}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        step();
        check_vec("fill.rom", {7'd0, rom_adrs}, 16'h0000);
        exp_slot("first", 9'h1FF, 1'b1);
        step();
        exp_slot("seq0", 9'h000, 1'b1);
        step();
        exp_slot("seq1", 9'h001, 1'b1);

        do_goto("g010", 9'h002, 9'h010);
        do_goto("g155", 9'h011, 9'h155);
        do_goto("g1f0", 9'h156, 9'h1F0);

        call_en = 1'b1; instr = 12'h080;
        redirect("call80", 9'h1F1, 9'h080);
        retlw_en = 1'b1;
        redirect("ret1f1", 9'h081, 9'h1F1);

        do_goto("g1fe", 9'h1F2, 9'h1FE);
        step();
        exp_slot("wrap1ff", 9'h1FF, 1'b1);
        step();
        exp_slot("wrap000", 9'h000, 1'b1);

        do_goto("g020", 9'h001, 9'h020);
        call_en = 1'b1; instr = 12'h080;
        redirect("callA", 9'h021, 9'h080);
        do_goto("g030", 9'h081, 9'h030);
        call_en = 1'b1; instr = 12'h090;
        redirect("callB", 9'h031, 9'h090);
        do_goto("g040", 9'h091, 9'h040);
        call_en = 1'b1; instr = 12'h0A0;
        redirect("callC", 9'h041, 9'h0A0);
        retlw_en = 1'b1;
        redirect("retA", 9'h0A1, 9'h041);
        retlw_en = 1'b1;
        redirect("retB", 9'h042, 9'h031);
        retlw_en = 1'b1;
        redirect("retC", 9'h032, 9'h031);

        pcl_wr = 1'b1; pcl_data = 8'hC5;
        redirect("pcl", 9'h032, 9'h0C5);
        goto_en = 1'b1; instr = 12'h050; pcl_wr = 1'b1; pcl_data = 8'h77;
        redirect("gpri", 9'h0C6, 9'h050);

        skip_en = 1'b1; skip_cond = 1'b1;
        step();
        clr_strobes();
        exp_slot("skipT.kill", 9'h051, 1'b0);
        step();
        exp_slot("skipT.run", 9'h052, 1'b1);
        skip_en = 1'b1; skip_cond = 1'b0; wdt_to = 1'b1;
        step();
        clr_strobes();
        exp_slot("skipF", 9'h053, 1'b1);

        // GOTO held into the killed slot must not retarget
        goto_en = 1'b1; instr = 12'h060;
        step();
        instr = 12'h100;
        exp_slot("gign.kill", 9'h054, 1'b0);
        step();
        clr_strobes();
        exp_slot("gign.land", 9'h060, 1'b1);

        sleep_en = 1'b1; goto_en = 1'b1; instr = 12'h0AA;
        step();
        clr_strobes();
        check_vec("slp.halt", {15'd0, halted}, 16'h0001);
        exp_slot("slp", 9'h060, 1'b0);
        for (int i = 0; i < 100; i++) begin
            goto_en = i[0]; pcl_wr = i[0]; instr = 12'h033; pcl_data = 8'h44;
            step();
            check_vec("slp.rom", {7'd0, rom_adrs}, 16'h0061);
        end
        clr_strobes();
        check_vec("slp.halt2", {15'd0, halted}, 16'h0001);

        wdt_to = 1'b1;
        step();
        clr_strobes();
        check_vec("wake.rom", {7'd0, rom_adrs}, 16'h01FF);
        check_vec("wake.halt", {15'd0, halted}, 16'h0000);
        check_vec("wake.ev", {15'd0, exec_valid}, 16'h0000);
        step();
        exp_slot("wake.first", 9'h1FF, 1'b1);
        step();
        exp_slot("wake.seq", 9'h000, 1'b1);

        // Stack survives the WDT wake: S1 still holds 0x031
        retlw_en = 1'b1;
        redirect("retwake", 9'h001, 9'h031);

        goto_en = 1'b1; instr = 12'h123;
        step();
        clr_strobes();
        #2;
        rst = 1'b0;
        #1;
        check_vec("abort.rom", {7'd0, rom_adrs}, 16'h01FF);
        check_vec("abort.pc", {7'd0, pc}, 16'h01FF);
        check_vec("abort.ev", {15'd0, exec_valid}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        step();
        exp_slot("abort.first", 9'h1FF, 1'b1);
        check_vec("abort.rom2", {7'd0, rom_adrs}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
